// File: rtl/cnt_pkg.sv
// Shared definitions for the counter sequencer and the counter register it drives.
package cnt_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int PW_DEF    = 8;
    localparam int WCW_DEF   = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_FIN  = 3'd3;
    localparam logic [2:0] ST_ABRT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_RUN  = ST_RUN,
        S_FIN  = ST_FIN,
        S_ABRT = ST_ABRT
    } state_t;

endpackage

// File: rtl/cnt_sequencer_if.sv
// Command handshake between a command source and the counter sequencer.
interface cnt_sequencer_if
    import cnt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PW    = PW_DEF
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [WIDTH-1:0] CMD_VAL;
    logic             CMD_UP;
    logic             CMD_AUTO;
    logic [PW-1:0]    CMD_PRESC;

    modport master (
        output CMD_VALID, CMD_VAL, CMD_UP, CMD_AUTO, CMD_PRESC,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID, CMD_VAL, CMD_UP, CMD_AUTO, CMD_PRESC,
        output CMD_READY
    );
endinterface

// File: rtl/cnt_prescaler.sv
// Step-rate prescaler: TICK every PRESC+1 cycles while CLR is low.
module cnt_prescaler
    import cnt_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          CLK,
    input  logic          ARST,
    input  logic          CLR,
    input  logic [PW-1:0] PRESC,
    output logic          TICK
);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    assign TICK = (pcnt_q == PRESC);

    // Next prescaler count: held at 0 while cleared, wraps to 0 on a tick.
    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        if (CLR || TICK) begin
            pcnt_d = '0;
        end
    end

    // Prescaler count register.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/cnt_sequencer.sv
// Command-driven sequencer for the loadable up/down counter register.
//
// state | meaning
// IDLE  | waiting for a command, CMD_READY high
// LOAD  | loads the counter with the start value (0 when counting up)
// RUN   | steps the counter on each prescaler tick until T_IN hits terminal
// FIN   | DONE pulse; reloads when AUTO, otherwise back to IDLE
// ABRT  | synchronous clear of the counter after ABORT
module cnt_sequencer
    import cnt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PW    = PW_DEF,
    parameter int WCW   = WCW_DEF
) (
    input  logic             CLK,
    input  logic             ARST,
    cnt_sequencer_if.slave   cmd,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] T_IN,
    output logic             CNT_CE,
    output logic             CNT_LOAD,
    output logic             CNT_INC,
    output logic             CNT_DEC,
    output logic             CNT_SRST,
    output logic [WIDTH-1:0] CNT_IN,
    output logic             DONE,
    output logic             BUSY,
    output logic [WCW-1:0]   WRAPS
);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] val_q,    val_d;
    logic             up_q,     up_d;
    logic             auto_q,   auto_d;
    logic [PW-1:0]    presc_q,  presc_d;
    logic [WCW-1:0]   wraps_q,  wraps_d;

    logic             tick;
    logic [WIDTH-1:0] term;

    cnt_prescaler #(.PW(PW)) u_presc (
        .CLK   (CLK),
        .ARST  (ARST),
        .CLR   (state_q != S_RUN),
        .PRESC (presc_q),
        .TICK  (tick)
    );

    assign term          = up_q ? val_q : '0;
    assign cmd.CMD_READY = (state_q == S_IDLE);
    assign BUSY          = (state_q != S_IDLE);
    assign WRAPS         = wraps_q;

    // Next-state, field updates and Moore counter controls.
    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        up_d     = up_q;
        auto_d   = auto_q;
        presc_d  = presc_q;
        wraps_d  = wraps_q;
        CNT_CE   = 1'b0;
        CNT_LOAD = 1'b0;
        CNT_INC  = 1'b0;
        CNT_DEC  = 1'b0;
        CNT_SRST = 1'b0;
        CNT_IN   = '0;
        DONE     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd.CMD_VALID) begin
                    val_d   = cmd.CMD_VAL;
                    up_d    = cmd.CMD_UP;
                    auto_d  = cmd.CMD_AUTO;
                    presc_d = cmd.CMD_PRESC;
                    wraps_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                CNT_CE   = 1'b1;
                CNT_LOAD = 1'b1;
                CNT_IN   = up_q ? '0 : val_q;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (tick) begin
                    if (T_IN == term) begin
                        state_d = S_FIN;
                    end else begin
                        CNT_CE  = 1'b1;
                        CNT_INC = up_q;
                        CNT_DEC = ~up_q;
                    end
                end
            end
            S_FIN: begin
                DONE = 1'b1;
                if (auto_q) begin
                    wraps_d = wraps_q + 1'b1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ABRT: begin
                CNT_SRST = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ABORT pre-empts any transition, including an auto-reload's WRAPS bump.
        if (ABORT && (state_q == S_LOAD || state_q == S_RUN || state_q == S_FIN)) begin
            state_d = S_ABRT;
            wraps_d = wraps_q;
        end
    end

    // State and latched command fields.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            up_q    <= 1'b0;
            auto_q  <= 1'b0;
            presc_q <= '0;
            wraps_q <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            up_q    <= up_d;
            auto_q  <= auto_d;
            presc_q <= presc_d;
            wraps_q <= wraps_d;
        end
    end

endmodule

// File: tb/tb_cnt_sequencer.sv
// Bench for cnt_sequencer: behavioural counter, per-cycle schedule model,
// directed literal scenarios and a randomized command/abort/reset phase.
module tb_cnt_sequencer;

    logic       CLK = 1'b0;
    logic       ARST = 1'b1;
    logic       ABORT = 1'b0;
    logic [3:0] t;
    logic       CNT_CE, CNT_LOAD, CNT_INC, CNT_DEC, CNT_SRST, DONE, BUSY;
    logic [3:0] CNT_IN;
    logic [7:0] WRAPS;

    int n_vec = 0;
    int n_err = 0;

    cnt_sequencer_if #(.WIDTH(4), .PW(8)) cif ();

    cnt_sequencer #(.WIDTH(4), .PW(8), .WCW(8)) dut (
        .CLK      (CLK),
        .ARST     (ARST),
        .cmd      (cif),
        .ABORT    (ABORT),
        .T_IN     (t),
        .CNT_CE   (CNT_CE),
        .CNT_LOAD (CNT_LOAD),
        .CNT_INC  (CNT_INC),
        .CNT_DEC  (CNT_DEC),
        .CNT_SRST (CNT_SRST),
        .CNT_IN   (CNT_IN),
        .DONE     (DONE),
        .BUSY     (BUSY),
        .WRAPS    (WRAPS)
    );

    always #5 CLK = ~CLK;

    // Downstream counter register driven by the sequencer.
    always @(posedge CLK or posedge ARST) begin
        if (ARST)          t <= 4'd0;
        else if (CNT_SRST) t <= 4'd0;
        else if (CNT_CE) begin
            if (CNT_LOAD)     t <= CNT_IN;
            else if (CNT_INC) t <= t + 4'd1;
            else if (CNT_DEC) t <= t - 4'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of expected per-cycle outputs
    typedef struct packed {
        logic       ce;
        logic       load;
        logic       inc;
        logic       dec;
        logic       srst;
        logic       done;
        logic [3:0] cin;
    } rec_t;

    rec_t       mq[$];
    logic [3:0] m_val;
    logic       m_up, m_auto;
    logic [7:0] m_presc;
    logic [7:0] m_wraps = 8'd0;

    // One full pass: load cycle, (steps+1) prescaler periods, done cycle.
    task automatic gen_pass();
        rec_t r;
        r = '0; r.ce = 1; r.load = 1; r.cin = m_up ? 4'd0 : m_val;
        mq.push_back(r);
        for (int k = 0; k <= int'(m_val); k++) begin
            for (int j = 0; j <= int'(m_presc); j++) begin
                r = '0;
                if (j == int'(m_presc) && k < int'(m_val)) begin
                    r.ce = 1; r.inc = m_up; r.dec = !m_up;
                end
                mq.push_back(r);
            end
        end
        r = '0; r.done = 1;
        mq.push_back(r);
    endtask

    initial begin
        rec_t cur, r;
        forever begin
            @(posedge CLK);
            if (ARST) begin
                mq.delete();
                m_wraps = 8'd0;
            end else if (mq.size() == 0) begin
                if (cif.CMD_VALID) begin
                    m_val = cif.CMD_VAL; m_up = cif.CMD_UP;
                    m_auto = cif.CMD_AUTO; m_presc = cif.CMD_PRESC;
                    m_wraps = 8'd0;
                    gen_pass();
                end
            end else begin
                cur = mq.pop_front();
                if (ABORT && !cur.srst) begin
                    mq.delete();
                    r = '0; r.srst = 1;
                    mq.push_back(r);
                end else if (cur.done && m_auto) begin
                    m_wraps = m_wraps + 8'd1;
                    gen_pass();
                end
            end
        end
    end

    // Compare every cycle, mid-cycle.
    initial begin
        rec_t e;
        logic idle;
        forever begin
            @(negedge CLK);
            idle = ARST || (mq.size() == 0);
            e = idle ? rec_t'(0) : mq[0];
            chk("m_ready", cif.CMD_READY, idle);
            chk("m_busy",  BUSY, !idle);
            chk("m_ce",    CNT_CE, e.ce);
            chk("m_load",  CNT_LOAD, e.load);
            chk("m_inc",   CNT_INC, e.inc);
            chk("m_dec",   CNT_DEC, e.dec);
            chk("m_srst",  CNT_SRST, e.srst);
            chk("m_done",  DONE, e.done);
            chk("m_cin",   CNT_IN, e.cin);
            chk("m_wraps", WRAPS, ARST ? 8'd0 : m_wraps);
        end
    end

    // ---------------- stimulus helpers
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [3:0] v, input logic up, input logic au,
                         input logic [7:0] p, input logic hold);
        cif.CMD_VAL = v; cif.CMD_UP = up; cif.CMD_AUTO = au; cif.CMD_PRESC = p;
        cif.CMD_VALID = 1'b1;
        @(negedge CLK);
        chk("start_ready", cif.CMD_READY, 1);
        cyc();
        if (!hold) cif.CMD_VALID = 1'b0;
    endtask

    // Cycle k (1..len) after acceptance: bit k of each pattern is the literal expectation.
    task automatic dir_run(input string nm, input int len,
                           input logic [31:0] ld, input logic [31:0] dec,
                           input logic [31:0] inc, input logic [31:0] dn,
                           input logic [31:0] sr, input logic [31:0] rdy,
                           input int abort_at, input int arst_at);
        for (int k = 1; k <= len; k++) begin
            ABORT = (k == abort_at);
            ARST  = (k == arst_at);
            @(negedge CLK);
            chk({nm, "_load"},  CNT_LOAD, ld[k]);
            chk({nm, "_dec"},   CNT_DEC, dec[k]);
            chk({nm, "_inc"},   CNT_INC, inc[k]);
            chk({nm, "_done"},  DONE, dn[k]);
            chk({nm, "_srst"},  CNT_SRST, sr[k]);
            chk({nm, "_ready"}, cif.CMD_READY, rdy[k]);
            cyc();
        end
        ABORT = 1'b0;
        ARST  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!cif.CMD_READY && n < 300) begin
            cyc();
            n++;
        end
        chk({nm, "_idle_timeout"}, cif.CMD_READY, 1);
    endtask

    initial begin
        cif.CMD_VALID = 1'b0; cif.CMD_VAL = 4'd0; cif.CMD_UP = 1'b0;
        cif.CMD_AUTO = 1'b0; cif.CMD_PRESC = 8'd0;
        ARST = 1'b1;
        cyc();
        @(negedge CLK);
        chk("rst_ready", cif.CMD_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_ce", CNT_CE, 0);
        chk("rst_wraps", WRAPS, 0);
        cyc();
        ARST = 1'b0;
        cyc();

        // down 3, presc 0: DEC in 2,3,4, DONE in 6, ready in 7
        start(4'd3, 1'b0, 1'b0, 8'd0, 1'b0);
        dir_run("down3", 7, 32'h2, 32'h1C, 32'h0, 32'h40, 32'h0, 32'h80, -1, -1);

        // up 2, presc 2: INC in 4 and 7, DONE in 11
        start(4'd2, 1'b1, 1'b0, 8'd2, 1'b0);
        dir_run("up2p2", 12, 32'h2, 32'h0, 32'h90, 32'h800, 32'h0, 32'h1000, -1, -1);

        // zero value: no step, DONE in 3
        start(4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        dir_run("zero", 4, 32'h2, 32'h0, 32'h0, 32'h8, 32'h0, 32'h10, -1, -1);

        // auto reload down 1: three passes, ABORT during the 4th pass's step cycle
        start(4'd1, 1'b0, 1'b1, 8'd0, 1'b0);
        dir_run("auto", 16, 32'h2222, 32'h4444, 32'h0, 32'h1110, 32'h8000, 32'h10000, 14, -1);
        @(negedge CLK);
        chk("auto_wraps", WRAPS, 3);
        chk("auto_t_cleared", t, 0);
        cyc();

        // ABORT in IDLE is ignored
        ABORT = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("idle_abort_srst", CNT_SRST, 0);
            chk("idle_abort_busy", BUSY, 0);
            cyc();
        end
        ABORT = 1'b0;

        // held command, ARST mid-RUN, then re-accepted on the first IDLE cycle
        start(4'd5, 1'b0, 1'b0, 8'd1, 1'b1);
        dir_run("arst", 6, 32'h42, 32'h8, 32'h0, 32'h0, 32'h0, 32'h30, -1, 4);
        cif.CMD_VALID = 1'b0;
        wait_idle("arst");
        @(negedge CLK);
        chk("arst_t_final", t, 0);
        cyc();

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            ARST  = ($urandom_range(0, 499) == 0);
            ABORT = (mq.size() != 0) && !mq[0].done && ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cif.CMD_VAL   = 4'($urandom_range(0, 15));
                cif.CMD_UP    = 1'($urandom_range(0, 1));
                cif.CMD_AUTO  = ($urandom_range(0, 3) == 0);
                cif.CMD_PRESC = 8'($urandom_range(0, 3));
            end
            cif.CMD_VALID = 1'($urandom_range(0, 1));
            cyc();
        end
        ARST = 1'b0;
        ABORT = 1'b1;
        cif.CMD_VALID = 1'b0;
        cyc();
        ABORT = 1'b0;
        wait_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
